// File: rtl/led_pkg.sv
// Shared definitions for the LED intensity sequencer: widths, command codes
// and FSM state encoding.
package led_pkg;

    localparam int unsigned LEVEL_W_DEFAULT = 4;
    localparam int unsigned RATE_W          = 4;
    localparam int unsigned MODE_W          = 2;

    localparam logic [MODE_W-1:0] MODE_SET     = 2'b00;
    localparam logic [MODE_W-1:0] MODE_RAMP    = 2'b01;
    localparam logic [MODE_W-1:0] MODE_BREATHE = 2'b10;
    localparam logic [MODE_W-1:0] MODE_OFF     = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RAMP = 2'b01,
        ST_BRU  = 2'b10,
        ST_BRD  = 2'b11
    } fade_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while enabled; tick is high
// whenever the count sits at TICK_DIV-1.
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(TICK_DIV - 2);

    logic [CNT_W-1:0] cnt_q;

    // tick is registered one count early so it coincides with cnt_q == CNT_LAST
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_q <= '0;
                tick  <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                tick  <= (cnt_q == CNT_PRE_LAST);
            end
        end
    end

endmodule

// File: rtl/led_fade_ctrl.sv
// Intensity sequencer for one LED PWM channel: SET / RAMP / BREATHE / OFF
// commands over valid/ready, producing a registered intensity word.
module led_fade_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned LEVEL_W  = LEVEL_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [MODE_W-1:0]  cmd_mode,
    input  logic [LEVEL_W-1:0] cmd_level,
    input  logic [RATE_W-1:0]  cmd_rate,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               done
);

    fade_state_t        state_q, state_d;
    logic [LEVEL_W-1:0] level_d;
    logic [LEVEL_W-1:0] target_q, target_d;
    logic [RATE_W-1:0]  rate_q, rate_d;
    logic [RATE_W-1:0]  step_cnt_q, step_cnt_d;
    logic               done_d;
    logic               accept;
    logic               tick;
    logic               tick_run;
    logic               step;

    assign accept   = cmd_valid && cmd_ready;
    assign tick_run = tick && (state_q != ST_IDLE);
    assign step     = tick_run && (step_cnt_q == rate_q);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (accept),
        .en    (state_q != ST_IDLE),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            level      <= '0;
            target_q   <= '0;
            rate_q     <= '0;
            step_cnt_q <= '0;
            done       <= 1'b0;
            busy       <= 1'b0;
            cmd_ready  <= 1'b1;
        end else begin
            state_q    <= state_d;
            level      <= level_d;
            target_q   <= target_d;
            rate_q     <= rate_d;
            step_cnt_q <= step_cnt_d;
            done       <= done_d;
            busy       <= (state_d != ST_IDLE);
            cmd_ready  <= (state_d != ST_RAMP);
        end
    end

    // An accepted command always wins over a step landing on the same edge
    always_comb begin
        state_d    = state_q;
        level_d    = level;
        target_d   = target_q;
        rate_d     = rate_q;
        step_cnt_d = step_cnt_q;
        done_d     = 1'b0;

        if (accept) begin
            target_d   = cmd_level;
            rate_d     = cmd_rate;
            step_cnt_d = '0;
            case (cmd_mode)
                MODE_SET: begin
                    level_d = cmd_level;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
                MODE_RAMP: begin
                    if (cmd_level == level) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RAMP;
                    end
                end
                MODE_BREATHE: begin
                    if (level < cmd_level) begin
                        state_d = ST_BRU;
                    end else begin
                        level_d = cmd_level;
                        state_d = ST_BRD;
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            endcase
        end else begin
            if (tick_run) begin
                step_cnt_d = step ? '0 : step_cnt_q + RATE_W'(1);
            end
            if (step) begin
                case (state_q)
                    ST_RAMP: begin
                        level_d = (target_q > level) ? level + LEVEL_W'(1)
                                                     : level - LEVEL_W'(1);
                        if (level_d == target_q) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    end
                    ST_BRU: begin
                        if (level < target_q) begin
                            level_d = level + LEVEL_W'(1);
                        end
                        if (level_d == target_q) begin
                            state_d = ST_BRD;
                        end
                    end
                    ST_BRD: begin
                        if (level != '0) begin
                            level_d = level - LEVEL_W'(1);
                        end
                        if (level_d == '0) begin
                            state_d = ST_BRU;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Self-checking bench for led_fade_ctrl: directed scenarios followed by a
// random command stream, all compared against a cycle-count reference model.
module tb_led_fade_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_mode;
    logic [3:0] cmd_level;
    logic [3:0] cmd_rate;
    logic [3:0] level;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;

    // Reference model: kind 0 = idle, 1 = ramping, 2 = breathing
    int m_level, m_kind, m_target, m_period, m_t, m_dir;
    bit m_done, m_busy, m_ready;

    led_fade_ctrl #(
        .TICK_DIV (TICK_DIV),
        .LEVEL_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_level (cmd_level),
        .cmd_rate  (cmd_rate),
        .level     (level),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_level = 0; m_kind = 0; m_target = 0; m_period = TICK_DIV;
        m_t = 0; m_dir = 1; m_done = 0; m_busy = 0; m_ready = 1;
    endfunction

    // Advance the model across one rising edge; steps fall on every
    // multiple of TICK_DIV*(rate+1) cycles after acceptance.
    function automatic void model_edge(input int v, input int m, input int l, input int r);
        m_done = 0;
        if (v != 0 && m_ready) begin
            m_t      = 0;
            m_period = TICK_DIV * (r + 1);
            m_target = l;
            case (m)
                0: begin m_level = l; m_kind = 0; m_done = 1; end
                1: begin
                    if (l == m_level) begin m_kind = 0; m_done = 1; end
                    else m_kind = 1;
                end
                2: begin
                    m_kind = 2;
                    if (m_level < l) m_dir = 1;
                    else begin m_level = l; m_dir = -1; end
                end
                default: begin m_level = 0; m_kind = 0; m_done = 1; end
            endcase
        end else if (m_kind != 0) begin
            m_t++;
            if (m_t % m_period == 0) begin
                if (m_kind == 1) begin
                    m_level += (m_target > m_level) ? 1 : -1;
                    if (m_level == m_target) begin m_kind = 0; m_done = 1; end
                end else if (m_dir > 0) begin
                    if (m_level < m_target) m_level++;
                    if (m_level == m_target) m_dir = -1;
                end else begin
                    if (m_level > 0) m_level--;
                    if (m_level == 0) m_dir = 1;
                end
            end
        end
        m_busy  = (m_kind != 0);
        m_ready = (m_kind != 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".level"}, 32'(level), 32'(m_level));
        chk({tag, ".done"}, 32'(done), 32'(m_done));
        chk({tag, ".busy"}, 32'(busy), 32'(m_busy));
        chk({tag, ".ready"}, 32'(cmd_ready), 32'(m_ready));
    endtask

    task automatic drive(input string tag, input logic v, input logic [1:0] m,
                         input logic [3:0] l, input logic [3:0] r);
        cmd_valid = v; cmd_mode = m; cmd_level = l; cmd_rate = r;
        model_edge(int'(v), int'(m), int'(l), int'(r));
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) drive(tag, 1'b0, 2'd0, 4'd0, 4'd0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; cmd_level = 4'd0; cmd_rate = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // SET 9 from reset
        drive("set9", 1'b1, 2'd0, 4'd9, 4'd0);
        chk("set9_level", 32'(level), 32'd9);
        chk("set9_done", 32'(done), 32'd1);
        idle("set9_after", 1);
        chk("set9_done_once", 32'(done), 32'd0);
        chk("set9_busy", 32'(busy), 32'd0);

        // RAMP 0->3 rate 1 with an ignored mid-ramp command
        drive("off", 1'b1, 2'd3, 4'd0, 4'd0);
        drive("ramp_up", 1'b1, 2'd1, 4'd3, 4'd1);
        for (int k = 1; k <= 24; k++) begin
            drive("ramp_up_run", (k == 10), 2'd0, 4'd15, 4'd0);
            if (k == 8)  chk("ramp_up_step1", 32'(level), 32'd1);
            if (k == 16) chk("ramp_up_step2", 32'(level), 32'd2);
            if (k == 23) chk("ramp_up_ready", 32'(cmd_ready), 32'd0);
        end
        chk("ramp_up_final", 32'(level), 32'd3);
        chk("ramp_up_done", 32'(done), 32'd1);
        chk("ramp_up_ready_back", 32'(cmd_ready), 32'd1);

        // RAMP 5->2 rate 0, then RAMP to current level
        drive("set5", 1'b1, 2'd0, 4'd5, 4'd0);
        drive("ramp_dn", 1'b1, 2'd1, 4'd2, 4'd0);
        idle("ramp_dn_run", 12);
        chk("ramp_dn_final", 32'(level), 32'd2);
        chk("ramp_dn_done", 32'(done), 32'd1);
        drive("ramp_same", 1'b1, 2'd1, 4'd2, 4'd3);
        chk("ramp_same_done", 32'(done), 32'd1);
        chk("ramp_same_busy", 32'(busy), 32'd0);

        // BREATHE peak 2 rate 0, then OFF mid-breathe
        drive("off2", 1'b1, 2'd3, 4'd0, 4'd0);
        drive("breathe2", 1'b1, 2'd2, 4'd2, 4'd0);
        idle("breathe2_run", 8);
        chk("breathe2_peak", 32'(level), 32'd2);
        idle("breathe2_run", 18);
        drive("breathe2_off", 1'b1, 2'd3, 4'd0, 4'd0);
        chk("breathe2_off_level", 32'(level), 32'd0);
        chk("breathe2_off_done", 32'(done), 32'd1);

        // BREATHE peak 0, then SET 7
        drive("breathe0", 1'b1, 2'd2, 4'd0, 4'd0);
        idle("breathe0_run", 44);
        chk("breathe0_level", 32'(level), 32'd0);
        chk("breathe0_busy", 32'(busy), 32'd1);
        drive("breathe0_set7", 1'b1, 2'd0, 4'd7, 4'd0);
        chk("breathe0_set7_level", 32'(level), 32'd7);

        // Asynchronous reset mid-ramp
        drive("off3", 1'b1, 2'd3, 4'd0, 4'd0);
        drive("ramp_rst", 1'b1, 2'd1, 4'd3, 4'd1);
        idle("ramp_rst_run", 10);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async_level", 32'(level), 32'd0);
        chk("rst_async_ready", 32'(cmd_ready), 32'd1);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_all("rst_release");

        // Random command stream
        for (int i = 0; i < 3000; i++) begin
            drive("rand", ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_fade_ctrl.md
# led_fade_ctrl

Intensity sequencer for the 4-bit sigma-delta LED PWM driver. It accepts commands over a valid/ready handshake and produces the driver's 4-bit intensity word. Commands either set a level immediately, ramp linearly to a target, breathe continuously between 0 and a peak, or switch the LED off. It sits between the register/command logic and the PWM accumulator, one instance per LED channel.

## Interface
- `TICK_DIV`, default 50000: clock cycles per base tick; must be ≥ 2.
- `LEVEL_W`, default 4: intensity width; matches the PWM driver input.
- `clk` in 1: system clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_mode` in 2: command code.
  - 00 SET, 01 RAMP, 10 BREATHE, 11 OFF.
- `cmd_level` in LEVEL_W: target (SET/RAMP) or peak (BREATHE).
- `cmd_rate` in 4: ticks per level step, minus 1.
- `level` out LEVEL_W: intensity to the PWM driver, registered.
- `busy` out 1: high in RAMP, BRU or BRD.
- `done` out 1: one-cycle pulse on command completion.

## Operation
- A command is accepted on a rising edge with `cmd_valid && cmd_ready`.
  - On acceptance, `cmd_level` and `cmd_rate` are latched.
  - The prescaler and step counter clear to 0 on acceptance.
- States: IDLE, RAMP, BRU (breathe up), BRD (breathe down).
- `cmd_ready` = 1 in IDLE, BRU and BRD; 0 in RAMP.
  - A ramp cannot be interrupted except by `reset`.
  - Breathing runs until the next accepted command.
- SET: on the accept edge, `level` ← `cmd_level`, `done` ← 1, state → IDLE.
- OFF: on the accept edge, `level` ← 0, `done` ← 1, state → IDLE, from any accepting state.
- RAMP:
  - If the target equals the current `level`: `done` ← 1 on the accept edge, stay IDLE, no step.
  - Otherwise state → RAMP. On each step, `level` moves ±1 toward the target.
  - On the step edge where `level` becomes the target: `done` ← 1, state → IDLE.
- BREATHE:
  - Entry: if current `level` < peak, state → BRU; otherwise `level` ← peak and state → BRD.
  - BRU: each step, `level` +1. On reaching the peak, state → BRD.
  - BRD: each step, `level` −1. On reaching 0, state → BRU.
  - Peak 0: `level` stays 0; the state toggles BRU/BRD on each step with no level change.
  - BREATHE never asserts `done`.
- Step generation:
  - The prescaler counts 0..TICK_DIV−1 and wraps; `tick` = (prescaler == TICK_DIV−1).
  - The step counter counts ticks 0..rate. A step occurs on the tick where counter == rate; the counter then returns to 0.
  - The prescaler and step counter run only in RAMP, BRU and BRD; they hold at 0 in IDLE.
- Arithmetic: `level` never wraps. Underflow below 0 and overflow above 2^LEVEL_W−1 are impossible by construction.

## Timing
- Reset values: `level`=0, state IDLE, `cmd_ready`=1, `busy`=0, `done`=0, all counters 0.
- SET/OFF latency: `level` updates on the accept edge itself; `done` is high the following cycle only.
- Step period: TICK_DIV × (cmd_rate+1) cycles.
  - First step edge = accept edge + TICK_DIV × (cmd_rate+1).
- A RAMP of distance d completes d × TICK_DIV × (cmd_rate+1) cycles after acceptance.
- `done` and the final `level` value appear in the same cycle. `cmd_ready` returns to 1 in that same cycle.
- A new command may be accepted in the cycle `done` is high.
- `busy` is a registered decode of the state.
- A command accepted while breathing takes effect on its accept edge. That edge's pending step, if any, is discarded.
- `reset` mid-operation immediately forces reset values asynchronously. Any pending `done` is lost.

## Structure
- Shared package `led_pkg`:
  - `LEVEL_W` default.
  - Mode codes `MODE_SET`, `MODE_RAMP`, `MODE_BREATHE`, `MODE_OFF`.
  - State enum `fade_state_t`.
- Sub-module `led_tick_gen`:
  - Parameterised by `TICK_DIV`, with inputs `clr` and `en` and output `tick`.
  - Provides the prescaler only. The step counter and FSM stay in `led_fade_ctrl`.

## Test plan
All scenarios use TICK_DIV=4.
- Reset mid-ramp: assert `reset` during a 0→3 ramp → `level`=0, IDLE, `cmd_ready`=1, `done`=0 immediately, with no clock edge needed.
- SET 9 from reset → `level`=9 on the accept edge; `done`=1 for exactly the next cycle; `busy` stays 0.
- RAMP 0→3, rate 1 → `level`=1,2,3 at accept+8, +16, +24.
  - `done`=1 only at +24.
  - `cmd_ready`=0 throughout; a `cmd_valid` pulse mid-ramp is not accepted.
- RAMP 5→2, rate 0 from `level`=5 → `level`=4,3,2 at +4, +8, +12; `done` at +12. RAMP to the current level → immediate `done` with no step.
- BREATHE peak 2, rate 0 from 0 → `level` sequence 1,2,1,0,1,2… every 4 cycles; `done` never asserts. OFF mid-breathe → `level`=0 and `done` on acceptance.
- BREATHE peak 0 → `level` stays 0 for ≥40 cycles, `busy`=1; a SET 7 issued afterwards is accepted and gives `level`=7.
